// File: rtl/enigma_pkg.sv
// Shared types for the Encryption-core stream framer: block layout and FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package enigma_pkg;

  localparam int BLK_BYTES = 16;

  typedef logic [7:0] byte_t;

  // Byte k of a block sits at index k; the core sees a0..a3, b0..b3, c0..c3, d0..d3.
  typedef byte_t [BLK_BYTES-1:0] blk_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Flatten a block into the core bus order: byte k at bits [8k+7:8k].
  function automatic logic [8*BLK_BYTES-1:0] pack_blk(input blk_t b);
    logic [8*BLK_BYTES-1:0] f;
    f = '0;
    for (int k = 0; k < BLK_BYTES; k++) begin
      f[8*k +: 8] = b[k];
    end
    return f;
  endfunction

  // Split a core bus back into indexed bytes (inverse of pack_blk).
  function automatic blk_t unpack_blk(input logic [8*BLK_BYTES-1:0] f);
    blk_t b;
    b = '0;
    for (int k = 0; k < BLK_BYTES; k++) begin
      b[k] = f[8*k +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/enigma_byte_buf.sv
// 16x8 register file: indexed byte write, parallel block load, sync clear, indexed + flat reads.
// Latency: writes visible the cycle after the edge; reads are combinational from registers.
// Backpressure: none; the owner decides when to write or load.
module enigma_byte_buf
  import enigma_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [3:0]             wr_idx_i,
  input  logic [7:0]             wr_dat_i,
  input  logic                   ld_en_i,
  input  logic [8*BLK_BYTES-1:0] ld_dat_i,
  input  logic [3:0]             rd_idx_i,
  output logic [7:0]             rd_dat_o,
  output logic [8*BLK_BYTES-1:0] flat_o
);

  blk_t mem_q;
  blk_t mem_d;

  // Next-state: clear wins over a parallel load, which wins over a single byte write.
  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      mem_d = '0;
    end else if (ld_en_i) begin
      mem_d = unpack_blk(ld_dat_i);
    end else if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_dat_i;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat_o = mem_q[rd_idx_i];
  assign flat_o   = pack_blk(mem_q);

endmodule

// File: rtl/enigma_stream_framer.sv
// Byte-serial framer around the combinational Encryption core: 16 bytes + key in, 16 bytes out.
// Latency: last input handshake at T -> first out_valid in cycle T+CALC_CYCLES+1.
// Backpressure: in_ready only in LOAD; out_valid holds data stable until out_ready accepts it.
module enigma_stream_framer #(
  parameter int CALC_CYCLES = 1,
  parameter int BLK_BYTES   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic [7:0]             key_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [8*BLK_BYTES-1:0] core_in,
  output logic [7:0]             core_sel,
  input  logic [8*BLK_BYTES-1:0] core_out,
  output logic                   busy,
  output logic                   blk_done
);

  import enigma_pkg::*;

  // calc_cnt needs at least one bit even when the core is single-cycle.
  localparam int          CW        = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_CYCLES - 1);
  localparam logic [3:0]  LAST      = 4'(BLK_BYTES - 1);
  localparam logic [3:0]  NEXT_LAST = 4'(BLK_BYTES - 2);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [CW-1:0] calc_cnt_q;
  logic [7:0]    key_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;

  logic          in_hs;
  logic          out_hs;
  logic          calc_done;
  logic [7:0]    obuf_rd;
  logic [7:0]    ibuf_rd_unused;
  logic [8*BLK_BYTES-1:0] obuf_flat_unused;

  // in_ready is masked by reset so nothing is taken while the block is being flushed.
  assign in_ready  = rst_n & in_ready_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign calc_done = (state_q == CALC) && (calc_cnt_q == CALC_LAST);

  // Input buffer: filled one byte per handshake; its flat view feeds the core directly,
  // so core_in only moves on input handshakes and stays put outside CALC.
  enigma_byte_buf u_ibuf (
    .clk      (clk),
    .clr_i    (!rst_n),
    .wr_en_i  (in_hs),
    .wr_idx_i (cnt_q),
    .wr_dat_i (in_data),
    .ld_en_i  (1'b0),
    .ld_dat_i ('0),
    .rd_idx_i (cnt_q),
    .rd_dat_o (ibuf_rd_unused),
    .flat_o   (core_in)
  );

  // Output buffer: captures the whole core result on the final CALC cycle.
  enigma_byte_buf u_obuf (
    .clk      (clk),
    .clr_i    (!rst_n),
    .wr_en_i  (1'b0),
    .wr_idx_i (4'd0),
    .wr_dat_i (8'd0),
    .ld_en_i  (calc_done),
    .ld_dat_i (core_out),
    .rd_idx_i (cnt_q),
    .rd_dat_o (obuf_rd),
    .flat_o   (obuf_flat_unused)
  );

  // Block FSM with counters, key capture and registered handshake/status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      calc_cnt_q  <= '0;
      key_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_hs) begin
            busy_q <= 1'b1;
            if (cnt_q == 4'd0) begin
              key_q <= key_i;
            end
            if (cnt_q == LAST) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= CALC;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        CALC: begin
          if (calc_done) begin
            calc_cnt_q  <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (LAST == 4'd0);
            state_q     <= DRAIN;
          end else begin
            calc_cnt_q <= calc_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= LOAD;
            end else begin
              cnt_q      <= cnt_q + 4'd1;
              out_last_q <= (cnt_q == NEXT_LAST);
            end
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  // Output data reads zero whenever no beat is being offered.
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? obuf_rd : 8'd0;
  assign out_last  = out_last_q;
  assign core_sel  = key_q;
  assign busy      = busy_q;
  assign blk_done  = out_hs & out_last_q;

endmodule

// File: doc/enigma_stream_framer.md
Name: enigma_stream_framer

Overview:
- Byte-serial front/back end for the combinational 16-byte Encryption core.
- Collects 16 plaintext bytes plus one 8-bit mode key over a valid/ready input stream and presents them to the core as a parallel block with select bits s0..s7.
- Captures the core result and streams the 16 cipher bytes out over a valid/ready output stream.
- Sits directly upstream and downstream of Encryption; the core instance is external and connected through the core_* ports.

Parameters:
- CALC_CYCLES, 1, cycles the block holds core inputs stable before sampling core_out (min 1; raise for a registered/pipelined core).
- BLK_BYTES, 16, bytes per block (fixed by the core; not to be overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  framer can accept input byte
- in_data  in  8  plaintext byte
- key_i  in  8  mode bits {s7..s0}; sampled with byte 0 of a block
- out_valid  out  1  cipher byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  cipher byte
- out_last  out  1  high with byte 15 of a block
- core_in  out  128  to core; byte k at [8k+7:8k]; k=0..15 maps to a0..a3, b0..b3, c0..c3, d0..d3
- core_sel  out  8  to core s0..s7 (bit i = si)
- core_out  in  128  from core; same byte order (w0..z3)
- busy  out  1  high in CALC or DRAIN, or LOAD with count>0
- blk_done  out  1  one-cycle pulse on the handshake of the last output byte

Behaviour:
- One clock, clk; reset is synchronous and active-low (rst_n). All state is updated on the rising clk edge.
- Reset (rst_n=0 at a clock edge):
  - state=LOAD, cnt=0, calc_cnt=0.
  - Input buffer, output buffer and key register cleared to 0.
  - Output values: core_in=0, core_sel=0, out_valid=0, out_last=0, blk_done=0, busy=0, out_data=0.
  - in_ready is forced 0 while rst_n=0.
- Reset mid-operation drops the partial or undelivered block silently. No output beat may appear after reset until a full new block is loaded.
- Handshakes:
  - A transfer occurs when valid and ready are both high at a clock edge.
  - out_valid, once high, stays high and out_data/out_last stay stable until accepted.
  - in_ready does not depend on in_valid.
- LOAD:
  - in_ready=1. On an input handshake: inbuf[cnt]<=in_data; if cnt==0, key<=key_i; cnt increments.
  - The handshake with cnt==15 sets cnt<=0 and moves to CALC.
- CALC:
  - in_ready=0. core_in=inbuf and core_sel=key, both driven directly from registers and stable throughout.
  - calc_cnt counts up to CALC_CYCLES-1. On that final CALC cycle, outbuf<=core_out, calc_cnt<=0, and the state moves to DRAIN.
- DRAIN:
  - out_valid=1, out_data=outbuf[cnt], out_last=(cnt==15).
  - On an output handshake cnt increments.
  - The handshake at cnt==15 pulses blk_done, sets cnt<=0 and moves to LOAD.
  - in_ready=0 throughout DRAIN (no input/output overlap).
- Latency:
  - Final input handshake at edge T; CALC spans cycles T+1..T+CALC_CYCLES; out_valid first high in cycle T+CALC_CYCLES+1.
  - At full throughput one block takes 16 + CALC_CYCLES + 16 cycles.
- Input gaps (in_valid low) and output stalls (out_ready low) of any length are legal; counters hold.
- core_in/core_sel keep their last values outside CALC. They change only on input handshakes and key capture.
- cnt is 4 bits and wraps only through the explicit 15→0 transitions; no other wrap-around.

Decomposition:
- Package enigma_pkg holds:
  - BLK_BYTES=16 and byte_t (logic [7:0]).
  - Typedef blk_t: 16 entries of byte_t.
  - Enum state_t {LOAD, CALC, DRAIN}.
  - Functions pack_blk/unpack_blk, converting between blk_t and the 128-bit core order.
- One sub-module, enigma_byte_buf: a 16x8 register file with a synchronous indexed byte write, a parallel 128-bit load, a sync clear, and indexed and 128-bit flat reads. Instantiated twice: input buffer (byte writes) and output buffer (parallel load).
- The FSM and counters stay in the top module.

Test Plan:
- Stream bytes 0x00..0x0F with key_i=0x00 and the core stubbed as identity, out_ready=1 -> out_data 0x00..0x0F in order; out_last only on 0x0F; blk_done one pulse; first out_valid exactly 2 cycles after the 16th input handshake.
- Key capture: key_i=0xA5 on byte 0, then 0x3C on bytes 1..15 -> core_sel==0xA5 throughout CALC. Also check core_in[7:0]==byte0 and core_in[127:120]==byte15.
- Backpressure: out_ready low 5 cycles at byte 7 -> out_data holds 0x07 with out_valid high; in_ready stays 0 until after byte 15 is accepted; no lost or duplicated bytes.
- Input gaps (in_valid toggling every cycle) and CALC_CYCLES=3 -> identical output sequence; first out_valid 4 cycles after the last input handshake.
- Reset at input byte 9, and separately at output byte 4 -> next cycle out_valid=0, busy=0, core_sel=0. A following full block is processed correctly with no residual bytes.
- Back-to-back blocks A then B -> block B's first input is accepted the cycle after A's out_last handshake; B's outputs are correct.
